// File: rtl/lifo_mc_pkg.sv
// Shared defaults and the command decode for the multi-channel LIFO stack.
// Defaults and the command decode used by lifo_mc_stack and lifo_mc_ptr.
package lifo_mc_pkg;

    localparam int LIFO_DATA_W = 8;
    localparam int LIFO_ADDR_W = 4;
    localparam int LIFO_NUM_CH = 4;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_FLUSH
    } lifo_op_e;

    // Flush dominates; push together with pop is a swap of the top entry.
    function automatic lifo_op_e decode_op(input logic push, input logic pop, input logic flush);
        lifo_op_e op;
        if (flush)
            op = OP_FLUSH;
        else if (push && pop)
            op = OP_SWAP;
        else if (push)
            op = OP_PUSH;
        else if (pop)
            op = OP_POP;
        else
            op = OP_IDLE;
        return op;
    endfunction

endpackage

// File: rtl/lifo_mc_ptr.sv
// Per-channel stack pointer: tracks occupancy (0..DEPTH), decodes full/empty,
// and raises overflow/underflow strobes for the command addressed to it.
module lifo_mc_ptr
    import lifo_mc_pkg::*;
#(
    parameter int ADDR_W = LIFO_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sel,
    input  lifo_op_e        op,
    output logic [ADDR_W:0] ptr,
    output logic            full,
    output logic            empty,
    output logic            ovf_stb,
    output logic            udf_stb
);

    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W + 1)'(1 << ADDR_W);

    logic [ADDR_W:0] ptr_reg;
    logic [ADDR_W:0] ptr_next;

    assign ptr   = ptr_reg;
    assign full  = (ptr_reg == PTR_FULL);
    assign empty = (ptr_reg == '0);

    always_comb begin
        ptr_next = ptr_reg;
        ovf_stb  = 1'b0;
        udf_stb  = 1'b0;
        if (sel) begin
            case (op)
                OP_FLUSH: ptr_next = '0;
                OP_PUSH: begin
                    if (full) ovf_stb = 1'b1;
                    else      ptr_next = ptr_reg + PTR_ONE;
                end
                OP_POP: begin
                    if (empty) udf_stb = 1'b1;
                    else       ptr_next = ptr_reg - PTR_ONE;
                end
                default: ptr_next = ptr_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_reg <= '0;
        else
            ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/lifo_mc_stack.sv
// Multi-channel LIFO: NUM_CH stacks sharing one memory addressed {ch, ptr}.
// Define LIFO_ERR_STICKY_EN to make ovf/udf sticky until err_clr; otherwise they pulse.
module lifo_mc_stack
    import lifo_mc_pkg::*;
#(
    parameter int DATA_W = LIFO_DATA_W,
    parameter int ADDR_W = LIFO_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int NUM_CH = LIFO_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CH_W-1:0]              cmd_ch,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [DATA_W-1:0]            d_in,
    input  logic                         err_clr,
    output logic [DATA_W-1:0]            d_out,
    output logic                         d_out_valid,
    output logic [CH_W-1:0]              d_out_ch,
    output logic [NUM_CH-1:0]            full,
    output logic [NUM_CH-1:0]            empty,
    output logic [NUM_CH*(ADDR_W+1)-1:0] count,
    output logic                         ovf,
    output logic                         udf
);

    localparam int MEM_AW = CH_W + ADDR_W;
    localparam logic [ADDR_W-1:0] OFS_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_BYP} dout_src_e;

    lifo_op_e          op;
    logic [ADDR_W:0]   ptr_arr [NUM_CH];
    logic [NUM_CH-1:0] ovf_vec;
    logic [NUM_CH-1:0] udf_vec;

    assign op = decode_op(push, pop, flush);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            lifo_mc_ptr #(.ADDR_W(ADDR_W)) u_ptr (
                .clk     (clk),
                .rst_n   (rst_n),
                .sel     (cmd_ch == CH_W'(gi)),
                .op      (op),
                .ptr     (ptr_arr[gi]),
                .full    (full[gi]),
                .empty   (empty[gi]),
                .ovf_stb (ovf_vec[gi]),
                .udf_stb (udf_vec[gi])
            );
            assign count[gi*(ADDR_W+1) +: ADDR_W+1] = ptr_arr[gi];
        end
    endgenerate

    logic [ADDR_W-1:0] sel_ofs;
    logic [ADDR_W-1:0] top_ofs;
    logic              sel_full;
    logic              sel_empty;
    logic              wr_en;
    logic              rd_en;
    logic              pass;
    logic [MEM_AW-1:0] wr_addr;
    logic [MEM_AW-1:0] rd_addr;

    assign sel_ofs   = ptr_arr[cmd_ch][ADDR_W-1:0];
    assign top_ofs   = sel_ofs - OFS_ONE;
    assign sel_full  = full[cmd_ch];
    assign sel_empty = empty[cmd_ch];

    // A swap writes the old top's slot; the registered read sees the pre-write value.
    assign wr_en   = ((op == OP_PUSH) && !sel_full) || ((op == OP_SWAP) && !sel_empty);
    assign rd_en   = ((op == OP_POP) || (op == OP_SWAP)) && !sel_empty;
    assign pass    = (op == OP_SWAP) && sel_empty;
    assign wr_addr = {cmd_ch, (op == OP_PUSH) ? sel_ofs : top_ofs};
    assign rd_addr = {cmd_ch, top_ofs};

    logic [DATA_W-1:0] mem [NUM_CH*DEPTH];
    logic [DATA_W-1:0] ram_q_reg;
    logic [DATA_W-1:0] byp_q_reg;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= d_in;
        if (rd_en)
            ram_q_reg <= mem[rd_addr];
        if (pass)
            byp_q_reg <= d_in;
    end

    dout_src_e         src_reg;
    logic              valid_reg;
    logic [CH_W-1:0]   ch_reg;
    logic              ovf_reg;
    logic              udf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg   <= SRC_NONE;
            valid_reg <= 1'b0;
            ch_reg    <= '0;
        end else begin
            valid_reg <= rd_en || pass;
            if (rd_en) begin
                src_reg <= SRC_RAM;
                ch_reg  <= cmd_ch;
            end else if (pass) begin
                src_reg <= SRC_BYP;
                ch_reg  <= cmd_ch;
            end
        end
    end

`ifdef LIFO_ERR_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else if (err_clr) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_reg || (|ovf_vec);
            udf_reg <= udf_reg || (|udf_vec);
        end
    end
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            ovf_reg <= |ovf_vec;
            udf_reg <= |udf_vec;
        end
    end
`endif

    always_comb begin
        d_out = '0;
        case (src_reg)
            SRC_RAM: d_out = ram_q_reg;
            SRC_BYP: d_out = byp_q_reg;
            default: d_out = '0;
        endcase
    end

    assign d_out_valid = valid_reg;
    assign d_out_ch    = ch_reg;
    assign ovf         = ovf_reg;
    assign udf         = udf_reg;

endmodule

// File: tb/tb_lifo_mc_stack.sv
// Scoreboard bench for lifo_mc_stack: queue-based reference stacks, directed and random commands.
module tb_lifo_mc_stack;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NCH   = 4;
    localparam int CW    = 2;

    logic              clk;
    logic              rst_n;
    logic [CW-1:0]     cmd_ch;
    logic              push;
    logic              pop;
    logic              flush;
    logic [DW-1:0]     d_in;
    logic              err_clr;
    logic [DW-1:0]     d_out;
    logic              d_out_valid;
    logic [CW-1:0]     d_out_ch;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH*(AW+1)-1:0] count;
    logic              ovf;
    logic              udf;

    lifo_mc_stack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_ch      (cmd_ch),
        .push        (push),
        .pop         (pop),
        .flush       (flush),
        .d_in        (d_in),
        .err_clr     (err_clr),
        .d_out       (d_out),
        .d_out_valid (d_out_valid),
        .d_out_ch    (d_out_ch),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .ovf         (ovf),
        .udf         (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] stk [NCH][$];
    logic          ovf_m;
    logic          udf_m;
    logic [DW-1:0] last_data;
    int            total;
    int            bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_state();
        logic [NCH*(AW+1)-1:0] c_exp;
        logic [NCH-1:0] f_exp;
        logic [NCH-1:0] e_exp;
        for (int c = 0; c < NCH; c++) begin
            c_exp[c*(AW+1) +: AW+1] = (AW+1)'(stk[c].size());
            f_exp[c] = (stk[c].size() == DEPTH);
            e_exp[c] = (stk[c].size() == 0);
        end
        check("count", 32'(count), 32'(c_exp));
        check("full", 32'(full), 32'(f_exp));
        check("empty", 32'(empty), 32'(e_exp));
        check("ovf", 32'(ovf), 32'(ovf_m));
        check("udf", 32'(udf), 32'(udf_m));
    endtask

    // Reference behaviour: plain queues, one per channel.
    task automatic model_step(input int ch, input bit p, input bit q, input bit f,
                              input logic [DW-1:0] din, input bit clr);
        bit   o = 0;
        bit   u = 0;
        exp_t e;
        e.ch = CW'(ch);
        if (f) begin
            stk[ch].delete();
        end else if (p && q) begin
            if (stk[ch].size() == 0) begin
                e.data = din;
            end else begin
                e.data = stk[ch][stk[ch].size()-1];
                stk[ch][stk[ch].size()-1] = din;
            end
            exp_q.push_back(e);
        end else if (p) begin
            if (stk[ch].size() == DEPTH) o = 1;
            else stk[ch].push_back(din);
        end else if (q) begin
            if (stk[ch].size() == 0) u = 1;
            else begin
                e.data = stk[ch].pop_back();
                exp_q.push_back(e);
            end
        end
`ifdef LIFO_ERR_STICKY_EN
        ovf_m = clr ? 1'b0 : (ovf_m | o);
        udf_m = clr ? 1'b0 : (udf_m | u);
`else
        ovf_m = o;
        udf_m = u;
`endif
    endtask

    // Called at a negedge; returns at the following negedge after checking state.
    task automatic do_cmd(input int ch, input bit p, input bit q, input bit f,
                          input logic [DW-1:0] din, input bit clr);
        cmd_ch  = CW'(ch);
        push    = p;
        pop     = q;
        flush   = f;
        d_in    = din;
        err_clr = clr;
        @(posedge clk);
        model_step(ch, p, q, f, din, clr);
        @(negedge clk);
        push    = 0;
        pop     = 0;
        flush   = 0;
        err_clr = 0;
        $display("cmd ch=%0d push=%0b pop=%0b flush=%0b din=%02h clr=%0b -> count=%05h ovf=%0b udf=%0b",
                 ch, p, q, f, din, clr, count, ovf, udf);
        check_state();
    endtask

    // Monitor: every valid output must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = '0;
        end else begin
            check("d_out_valid", 32'(d_out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (d_out_valid) begin
                    check("d_out", 32'(d_out), 32'(e.data));
                    check("d_out_ch", 32'(d_out_ch), 32'(e.ch));
                    last_data = e.data;
                end
            end else begin
                check("d_out_hold", 32'(d_out), 32'(last_data));
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        ovf_m = 0;
        udf_m = 0;
        rst_n = 0;
        cmd_ch = '0;
        push = 0;
        pop = 0;
        flush = 0;
        d_in = '0;
        err_clr = 0;
        repeat (3) @(negedge clk);
        check("rst_d_out", 32'(d_out), 32'h0);
        check("rst_valid", 32'(d_out_valid), 32'h0);
        check("rst_d_out_ch", 32'(d_out_ch), 32'h0);
        check_state();
        rst_n = 1;

        // Fill ch1, overflow, then drain and underflow.
        for (int i = 0; i < DEPTH; i++) do_cmd(1, 1, 0, 0, DW'(8'h10 + i), 0);
        do_cmd(1, 1, 0, 0, 8'hEE, 0);
        do_cmd(0, 0, 0, 0, 8'h00, 0);
        do_cmd(0, 0, 0, 0, 8'h00, 0);
        do_cmd(0, 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < DEPTH; i++) do_cmd(1, 0, 1, 0, 8'h00, 0);
        do_cmd(1, 0, 1, 0, 8'h00, 0);
        do_cmd(1, 0, 0, 0, 8'h00, 1);

        // Interleaved channels.
        do_cmd(0, 1, 0, 0, 8'hA0, 0);
        do_cmd(2, 1, 0, 0, 8'hB0, 0);
        do_cmd(0, 1, 0, 0, 8'hA1, 0);
        do_cmd(0, 0, 1, 0, 8'h00, 0);
        do_cmd(2, 0, 1, 0, 8'h00, 0);
        do_cmd(0, 0, 1, 0, 8'h00, 0);

        // Swap on a non-empty channel, pass-through on an empty one.
        do_cmd(3, 1, 0, 0, 8'h55, 0);
        do_cmd(3, 1, 1, 0, 8'h66, 0);
        do_cmd(3, 0, 1, 0, 8'h00, 0);
        do_cmd(2, 1, 1, 0, 8'h77, 0);

        // Flush overrides push.
        for (int i = 0; i < 3; i++) do_cmd(0, 1, 0, 0, DW'(8'hC0 + i), 0);
        do_cmd(0, 1, 0, 1, 8'hCF, 0);

        // Randomised traffic: push-heavy then pop-heavy.
        for (int n = 0; n < 600; n++) begin
            int  ch;
            int  r;
            int  bias;
            bit  p;
            bit  q;
            bias = (n < 300) ? 70 : 30;
            ch = $urandom_range(0, NCH-1);
            r  = $urandom_range(0, 99);
            p  = ($urandom_range(0, 99) < bias);
            q  = ($urandom_range(0, 99) >= bias);
            do_cmd(ch, p, q, (r < 3), DW'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset while a pop result is on the output.
        do_cmd(1, 1, 0, 0, 8'h42, 0);
        while (stk[1].size() != 1) do_cmd(1, 0, 1, 0, 8'h00, 0);
        cmd_ch = 2'd1;
        pop = 1;
        @(posedge clk);
        #1;
        pop = 0;
        check("pre_rst_valid", 32'(d_out_valid), 32'h1);
        check("pre_rst_d_out", 32'(d_out), 32'h42);
        rst_n = 0;
        for (int c = 0; c < NCH; c++) stk[c].delete();
        exp_q.delete();
        ovf_m = 0;
        udf_m = 0;
        #1;
        check("rst_mid_valid", 32'(d_out_valid), 32'h0);
        check("rst_mid_d_out", 32'(d_out), 32'h0);
        check_state();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        do_cmd(1, 0, 1, 0, 8'h00, 0);
        do_cmd(1, 1, 0, 0, 8'h99, 0);
        do_cmd(1, 0, 1, 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
